// File: rtl/difficulty_if.sv
// Control/status bundle between the game logic and difficulty_ctrl.
// The master drives game state and score; the slave (difficulty_ctrl) returns tick, gap and level.
interface difficulty_if;
    localparam int unsigned GS_W    = 4;
    localparam int unsigned SCORE_W = 32;
    localparam int unsigned GAP_W   = 8;
    localparam int unsigned LVL_W   = 4;

    logic [GS_W-1:0]    game_state;
    logic [SCORE_W-1:0] score_count;
    logic               move_tick;
    logic [GAP_W-1:0]   pipe_gap;
    logic [LVL_W-1:0]   level;
    logic               level_up;

    modport master (
        output game_state, score_count,
        input  move_tick, pipe_gap, level, level_up
    );

    modport slave (
        input  game_state, score_count,
        output move_tick, pipe_gap, level, level_up
    );
endinterface

// File: rtl/difficulty_ctrl.sv
// Pipe movement tick generator with score-driven difficulty levels (shorter period, narrower gap).
// Optional macro DIFF_SLEW_EN: period slews toward its target by DIV_STEP/4 per tick instead of jumping.
module difficulty_ctrl #(
    parameter int unsigned BASE_DIV   = 199999,
    parameter int unsigned DIV_STEP   = 20000,
    parameter int unsigned MIN_DIV    = 99999,
    parameter int unsigned SCORE_STEP = 5,
    parameter int unsigned MAX_LEVEL  = 5,
    parameter int unsigned GAP_BASE   = 75,
    parameter int unsigned GAP_STEP   = 5,
    parameter int unsigned GAP_MIN    = 55
) (
    input  logic         clk,
    input  logic         rst,
    difficulty_if.slave  bus
);
    localparam int unsigned CNT_W = 32;
    localparam int unsigned LVL_W = 4;
    localparam int unsigned GAP_W = 8;
    localparam int unsigned GS_W  = 4;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_HOLD, S_FROZEN} state_t;

    state_t             r_state, w_state_nxt;
    logic [GS_W-1:0]    r_gs;
    logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
    logic [CNT_W-1:0]   r_cur_div, w_cur_div_nxt;
    logic [CNT_W-1:0]   r_next_thr, w_next_thr_nxt;
    logic [LVL_W-1:0]   r_level, w_level_nxt;
    logic [GAP_W-1:0]   r_pipe_gap, w_pipe_gap_nxt;
    logic               r_move_tick, w_move_tick_nxt;
    logic               r_level_up, w_level_up_nxt;

    logic [CNT_W-1:0]   w_div_dec, w_target_div, w_wrap_div;
    logic [CNT_W-1:0]   w_gap_dec;
    logic [GAP_W-1:0]   w_level_gap;
    logic               w_gs_run, w_gs_hold, w_gs_over;

    assign w_gs_run  = (r_gs == GS_W'(1));
    assign w_gs_hold = (r_gs == GS_W'(2));
    assign w_gs_over = (r_gs == GS_W'(3));

    // Level-derived period and gap; clamp is decided before subtracting so nothing underflows.
    assign w_div_dec    = CNT_W'(r_level) * DIV_STEP;
    assign w_target_div = (w_div_dec >= (BASE_DIV - MIN_DIV)) ? CNT_W'(MIN_DIV)
                                                              : CNT_W'(BASE_DIV - w_div_dec);
    assign w_gap_dec    = CNT_W'(r_level) * GAP_STEP;
    assign w_level_gap  = (w_gap_dec >= (GAP_BASE - GAP_MIN)) ? GAP_W'(GAP_MIN)
                                                              : GAP_W'(GAP_BASE - w_gap_dec);

`ifdef DIFF_SLEW_EN
    localparam int unsigned SLEW_RAW = DIV_STEP / 4;
    localparam int unsigned SLEW     = (SLEW_RAW == 0) ? 1 : SLEW_RAW;

    // Period applied at the next wrap: one bounded step toward the target.
    always_comb begin
        w_wrap_div = w_target_div;
        if (r_cur_div > w_target_div) begin
            if ((r_cur_div - w_target_div) > CNT_W'(SLEW))
                w_wrap_div = r_cur_div - CNT_W'(SLEW);
        end else if (r_cur_div < w_target_div) begin
            if ((w_target_div - r_cur_div) > CNT_W'(SLEW))
                w_wrap_div = r_cur_div + CNT_W'(SLEW);
        end
    end
`else
    assign w_wrap_div = w_target_div;
`endif

    // State and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_gs        <= '0;
            r_cnt       <= '0;
            r_cur_div   <= CNT_W'(BASE_DIV);
            r_next_thr  <= CNT_W'(SCORE_STEP);
            r_level     <= '0;
            r_pipe_gap  <= GAP_W'(GAP_BASE);
            r_move_tick <= 1'b0;
            r_level_up  <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_gs        <= bus.game_state;
            r_cnt       <= w_cnt_nxt;
            r_cur_div   <= w_cur_div_nxt;
            r_next_thr  <= w_next_thr_nxt;
            r_level     <= w_level_nxt;
            r_pipe_gap  <= w_pipe_gap_nxt;
            r_move_tick <= w_move_tick_nxt;
            r_level_up  <= w_level_up_nxt;
        end
    end

    // Next state and next register values.
    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = r_cnt;
        w_cur_div_nxt   = r_cur_div;
        w_next_thr_nxt  = r_next_thr;
        w_level_nxt     = r_level;
        w_pipe_gap_nxt  = w_level_gap;
        w_move_tick_nxt = 1'b0;
        w_level_up_nxt  = 1'b0;

        unique case (r_state)
            S_IDLE: begin
                w_cnt_nxt      = '0;
                w_cur_div_nxt  = CNT_W'(BASE_DIV);
                w_level_nxt    = '0;
                w_next_thr_nxt = CNT_W'(SCORE_STEP);
                w_pipe_gap_nxt = GAP_W'(GAP_BASE);
                if (w_gs_run)
                    w_state_nxt = S_RUN;
            end
            S_RUN: begin
                if (r_cnt == r_cur_div) begin
                    w_move_tick_nxt = 1'b1;
                    w_cnt_nxt       = '0;
                    w_cur_div_nxt   = w_wrap_div;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
                if ((bus.score_count >= r_next_thr) && (r_level < LVL_W'(MAX_LEVEL))) begin
                    w_level_nxt    = r_level + LVL_W'(1);
                    w_next_thr_nxt = r_next_thr + CNT_W'(SCORE_STEP);
                    w_level_up_nxt = 1'b1;
                end
                if (w_gs_hold)
                    w_state_nxt = S_HOLD;
                else if (w_gs_over)
                    w_state_nxt = S_FROZEN;
                else if (!w_gs_run)
                    w_state_nxt = S_IDLE;
            end
            S_HOLD: begin
                if (w_gs_run)
                    w_state_nxt = S_RUN;
                else if (w_gs_over)
                    w_state_nxt = S_FROZEN;
                else if (!w_gs_hold)
                    w_state_nxt = S_IDLE;
            end
            S_FROZEN: begin
                if (!w_gs_run && !w_gs_hold && !w_gs_over)
                    w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign bus.move_tick = r_move_tick;
    assign bus.pipe_gap  = r_pipe_gap;
    assign bus.level     = r_level;
    assign bus.level_up  = r_level_up;

endmodule
